// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries with synchronous flush.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  // A pop frees the slot this cycle, so push-when-full is still safe.
  assign do_push = push & ~flush & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding req/ack read, PC advance pulse, decode FIFO.
// Optional IFETCH_BYPASS_EN forwards read data straight to decode when the FIFO is empty.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_ena,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t         state;
  fetch_entry_t   head;
  fetch_entry_t   din;
  logic [CW-1:0]  count;
  logic [CW-1:0]  next_count;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           bypass;

  assign pc_ena = (state == REQ) & imem_ack & ~flush;

`ifdef IFETCH_BYPASS_EN
  assign bypass = pc_ena & empty;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = ~empty | bypass;
  assign inst       = ~empty ? head.inst : (bypass ? imem_rdata : '0);
  assign inst_pc    = ~empty ? head.pc   : (bypass ? imem_addr  : '0);

  // A bypassed word that decode takes immediately never occupies a slot.
  assign push = pc_ena & ~(bypass & inst_ready);
  assign pop  = ~empty & inst_ready & ~flush;
  assign din  = '{pc: imem_addr, inst: imem_rdata};

  always_comb begin
    next_count = count;
    if (push) next_count = next_count + CW'(1);
    if (pop)  next_count = next_count - CW'(1);
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && !full) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (!flush && next_count != CW'(DEPTH)) begin
              imem_addr <= pc_in;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (flush) begin
            // The request stays up; its data is discarded when it lands.
            state <= KILL;
          end
        end
        KILL: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
